// File: rtl/dmem_access_seq.sv
// Sequences EX/MEM data-memory accesses into registered strobes with WAIT_CYCLES wait states.
// Stalls the pipeline from acceptance until DONE; illegal read+write requests pulse err instead.
module dmem_access_seq #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic              DmemREB,
  output logic              DmemWEB,
  output logic [ADDR_W-1:0] DmemAddr,
  output logic [DATA_W-1:0] DmemWData,
  input  logic [DATA_W-1:0] DmemRData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       acc_rd, acc_wr, last;

  assign last = (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    stall     = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (mem_en && !rd_n && wr_n) begin
          acc_rd    = 1'b1;
          state_nxt = READ;
        end else if (mem_en && rd_n && !wr_n) begin
          acc_wr    = 1'b1;
          state_nxt = WRITE;
        end else if (mem_en && !rd_n && !wr_n) begin
          err = 1'b1;
        end
        stall = acc_rd | acc_wr;
      end
      READ, WRITE: begin
        stall = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset must silence the combinational outputs even while a request is presented.
    if (rst) begin
      stall = 1'b0;
      err   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 4'd0;
      DmemREB     <= 1'b1;
      DmemWEB     <= 1'b1;
      DmemAddr    <= '0;
      DmemWData   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      if (acc_rd) begin
        DmemAddr <= addr;
        cnt      <= WAIT_LD;
        DmemREB  <= 1'b0;
      end
      if (acc_wr) begin
        DmemAddr  <= addr;
        DmemWData <= wdata;
        cnt       <= WAIT_LD;
        DmemWEB   <= 1'b0;
      end
      if (state == READ || state == WRITE) begin
        if (last) begin
          DmemREB <= 1'b1;
          DmemWEB <= 1'b1;
          if (state == READ) begin
            rdata       <= DmemRData;
            rdata_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Bench for dmem_access_seq: directed vector table, reset/back-to-back sequences, random vs. age-based model.
module tb_dmem_access_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
  logic [31:0] addr = '0, wdata = '0, drd = '0;

  logic [1:0]  stall_o, rv_o, err_o, reb_o, web_o;
  logic [31:0] rdata_o [2];
  logic [31:0] daddr_o [2];
  logic [31:0] dwd_o   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_seq #(.WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .wdata(wdata), .stall(stall_o[0]), .rdata(rdata_o[0]),
    .rdata_valid(rv_o[0]), .err(err_o[0]), .DmemREB(reb_o[0]), .DmemWEB(web_o[0]),
    .DmemAddr(daddr_o[0]), .DmemWData(dwd_o[0]), .DmemRData(drd)
  );

  dmem_access_seq #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .wdata(wdata), .stall(stall_o[1]), .rdata(rdata_o[1]),
    .rdata_valid(rv_o[1]), .err(err_o[1]), .DmemREB(reb_o[1]), .DmemWEB(web_o[1]),
    .DmemAddr(daddr_o[1]), .DmemWData(dwd_o[1]), .DmemRData(drd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic en, input logic rn, input logic wn,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    mem_en = en; rd_n = rn; wr_n = wn; addr = a; wdata = wd; drd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(0, 1, 1, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        en, rn, wn;
    logic [31:0] a, wd, rd;
    logic        st, reb, web, rv, er;
    logic [31:0] rdat, ea, ewd;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rn, input logic wn,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic st, input logic reb, input logic web, input logic rv,
                              input logic er, input logic [31:0] rdat, input logic [31:0] ea,
                              input logic [31:0] ewd);
    vec_t v;
    v.en = en; v.rn = rn; v.wn = wn; v.a = a; v.wd = wd; v.rd = rd;
    v.st = st; v.reb = reb; v.web = web; v.rv = rv; v.er = er;
    v.rdat = rdat; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  // Reference model: tracks cycles elapsed since acceptance rather than FSM states.
  int          age   [2];
  bit          isrd  [2];
  logic [31:0] m_addr[2], m_wd[2], m_rd[2];

  function automatic int wv(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i] = 0; isrd[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_rd[i] = '0;
    end
  endtask

  task automatic model_cycle();
    for (int i = 0; i < 2; i++) begin
      int  w;
      bit  idle, ard, awr, ill, busy;
      w    = wv(i);
      idle = (age[i] == 0);
      ard  = idle && mem_en && !rd_n && wr_n;
      awr  = idle && mem_en && rd_n && !wr_n;
      ill  = idle && mem_en && !rd_n && !wr_n;
      busy = (age[i] >= 1) && (age[i] <= w + 1);
      chk($sformatf("rnd%0d_stall", i), {31'b0, stall_o[i]}, {31'b0, ard | awr | busy});
      chk($sformatf("rnd%0d_err", i),   {31'b0, err_o[i]},   {31'b0, ill});
      chk($sformatf("rnd%0d_reb", i),   {31'b0, reb_o[i]},   {31'b0, !(busy && isrd[i])});
      chk($sformatf("rnd%0d_web", i),   {31'b0, web_o[i]},   {31'b0, !(busy && !isrd[i])});
      chk($sformatf("rnd%0d_rv", i),    {31'b0, rv_o[i]},    {31'b0, isrd[i] && age[i] == w + 2});
      chk($sformatf("rnd%0d_rdata", i), rdata_o[i], m_rd[i]);
      chk($sformatf("rnd%0d_addr", i),  daddr_o[i], m_addr[i]);
      chk($sformatf("rnd%0d_wdata", i), dwd_o[i],   m_wd[i]);
      if (ard || awr) begin
        age[i] = 1; isrd[i] = ard; m_addr[i] = addr;
        if (awr) m_wd[i] = wdata;
      end else if (age[i] == w + 2) begin
        age[i] = 0;
      end else if (age[i] > 0) begin
        if (isrd[i] && age[i] == w + 1) m_rd[i] = drd;
        age[i]++;
      end
    end
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = mk(1, 0, 1, 32'h100, 0, 0,              1, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0,                    1, 0, 1, 0, 0, 0, 32'h100, 0);
    tbl[2]  = mk(1, 0, 1, 32'h999, 0, 0,              1, 0, 1, 0, 0, 0, 32'h100, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 32'hDEADBEEF,         1, 0, 1, 0, 0, 0, 32'h100, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0,                    0, 1, 1, 1, 0, 32'hDEADBEEF, 32'h100, 0);
    tbl[5]  = mk(1, 1, 0, 32'h40, 32'h12345678, 0,    1, 1, 1, 0, 0, 32'hDEADBEEF, 32'h100, 0);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0,                    1, 1, 0, 0, 0, 32'hDEADBEEF, 32'h40, 32'h12345678);
    tbl[7]  = mk(0, 1, 1, 0, 0, 0,                    1, 1, 0, 0, 0, 32'hDEADBEEF, 32'h40, 32'h12345678);
    tbl[8]  = mk(0, 1, 1, 0, 0, 32'hFFFFFFFF,         1, 1, 0, 0, 0, 32'hDEADBEEF, 32'h40, 32'h12345678);
    tbl[9]  = mk(0, 1, 1, 0, 0, 0,                    0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h40, 32'h12345678);
    tbl[10] = mk(1, 0, 0, 32'h77, 32'h55, 0,          0, 1, 1, 0, 1, 32'hDEADBEEF, 32'h40, 32'h12345678);
    tbl[11] = mk(0, 1, 1, 0, 0, 0,                    0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h40, 32'h12345678);

    // Reset values, with a read request presented during reset.
    drv(1, 0, 1, 32'h123, 32'h456, 32'h789);
    #12;
    chk("rst_stall", {31'b0, stall_o[0]}, 32'd0);
    chk("rst_err",   {31'b0, err_o[0]},   32'd0);
    chk("rst_reb",   {31'b0, reb_o[0]},   32'd1);
    chk("rst_web",   {31'b0, web_o[0]},   32'd1);
    chk("rst_rv",    {31'b0, rv_o[0]},    32'd0);
    chk("rst_rdata", rdata_o[0], 32'd0);
    chk("rst_addr",  daddr_o[0], 32'd0);
    chk("rst_wdata", dwd_o[0],   32'd0);

    // Directed table on the WAIT_CYCLES=2 instance: read, write, illegal.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drv(tbl[k].en, tbl[k].rn, tbl[k].wn, tbl[k].a, tbl[k].wd, tbl[k].rd);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", k), {31'b0, stall_o[0]}, {31'b0, tbl[k].st});
      chk($sformatf("vec%0d_reb", k),   {31'b0, reb_o[0]},   {31'b0, tbl[k].reb});
      chk($sformatf("vec%0d_web", k),   {31'b0, web_o[0]},   {31'b0, tbl[k].web});
      chk($sformatf("vec%0d_rv", k),    {31'b0, rv_o[0]},    {31'b0, tbl[k].rv});
      chk($sformatf("vec%0d_err", k),   {31'b0, err_o[0]},   {31'b0, tbl[k].er});
      chk($sformatf("vec%0d_rdata", k), rdata_o[0], tbl[k].rdat);
      chk($sformatf("vec%0d_addr", k),  daddr_o[0], tbl[k].ea);
      chk($sformatf("vec%0d_wdata", k), dwd_o[0],   tbl[k].ewd);
      tick();
    end

    // Asynchronous reset in the middle of a read, then a clean read.
    do_reset();
    drv(1, 0, 1, 32'h200, 0, 32'h11111111);
    tick();
    drv(0, 1, 1, 0, 0, 32'h11111111);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_reb",   {31'b0, reb_o[0]},   32'd1);
    chk("arst_stall", {31'b0, stall_o[0]}, 32'd0);
    chk("arst_rdata", rdata_o[0], 32'd0);
    chk("arst_rv",    {31'b0, rv_o[0]},    32'd0);
    tick();
    rst = 1'b0;
    drv(1, 0, 1, 32'h300, 0, 32'hCAFEF00D);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rerd_c%0d_stall", c), {31'b0, stall_o[0]}, 32'd1);
      chk($sformatf("rerd_c%0d_reb", c),   {31'b0, reb_o[0]},   (c == 0) ? 32'd1 : 32'd0);
      tick();
      drv(0, 1, 1, 0, 0, 32'hCAFEF00D);
    end
    @(negedge clk);
    chk("rerd_rv",    {31'b0, rv_o[0]}, 32'd1);
    chk("rerd_rdata", rdata_o[0], 32'hCAFEF00D);
    chk("rerd_addr",  daddr_o[0], 32'h300);
    tick();

    // Back-to-back read then write on the WAIT_CYCLES=0 instance.
    do_reset();
    drv(1, 0, 1, 32'h10, 0, 32'hA5A5A5A5);
    @(negedge clk);
    chk("b2b_c0_stall", {31'b0, stall_o[1]}, 32'd1);
    tick();
    drv(1, 1, 0, 32'h20, 32'h0000BEEF, 32'hA5A5A5A5);
    @(negedge clk);
    chk("b2b_c1_reb",   {31'b0, reb_o[1]},   32'd0);
    chk("b2b_c1_stall", {31'b0, stall_o[1]}, 32'd1);
    tick();
    drv(1, 1, 0, 32'h20, 32'h0000BEEF, 32'h0);
    @(negedge clk);
    chk("b2b_c2_rv",    {31'b0, rv_o[1]},    32'd1);
    chk("b2b_c2_rdata", rdata_o[1], 32'hA5A5A5A5);
    chk("b2b_c2_stall", {31'b0, stall_o[1]}, 32'd0);
    chk("b2b_c2_reb",   {31'b0, reb_o[1]},   32'd1);
    tick();
    @(negedge clk);
    chk("b2b_c3_stall", {31'b0, stall_o[1]}, 32'd1);
    chk("b2b_c3_web",   {31'b0, web_o[1]},   32'd1);
    tick();
    drv(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("b2b_c4_web",   {31'b0, web_o[1]},   32'd0);
    chk("b2b_c4_addr",  daddr_o[1], 32'h20);
    chk("b2b_c4_wdata", dwd_o[1],   32'h0000BEEF);
    tick();
    @(negedge clk);
    chk("b2b_c5_web",   {31'b0, web_o[1]},   32'd1);
    chk("b2b_c5_stall", {31'b0, stall_o[1]}, 32'd0);
    chk("b2b_c5_rv",    {31'b0, rv_o[1]},    32'd0);
    chk("b2b_c5_rdata", rdata_o[1], 32'hA5A5A5A5);
    tick();

    // Random traffic on both instances against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      drv($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom);
      @(negedge clk);
      model_cycle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
